hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised load-use hazard unit for the in-order pipeline; replaces single-cycle EX/MEM compare with a per-register scoreboard.
- Tracks destination registers of in-flight loads for a configurable load latency and stalls issue from ID while any source or destination register is pending.
- Sits between the decode stage and the ID/EX register; its stall output freezes PC and IF/ID and injects a bubble into ID/EX.

Parameters:
- REG_ADDR_W, 5, register address width.
- NUM_REGS, 32, architectural register count (must equal 2**REG_ADDR_W).
- LOAD_LAT, 2, cycles after issue before a load result is forwardable (1..7).
- CNT_W, 3, per-register countdown width (must hold LOAD_LAT).

Ports:
- clk  input  1  pipeline clock.
- rst_n  input  1  asynchronous active-low reset.
- id_valid  input  1  ID holds a valid instruction.
- id_is_load  input  1  ID instruction is a load (mem_reg).
- id_write_reg  input  REG_ADDR_W  ID destination register.
- id_reg_write  input  1  ID instruction writes id_write_reg.
- id_read_reg1  input  REG_ADDR_W  ID source 1.
- id_read_reg2  input  REG_ADDR_W  ID source 2.
- id_use_reg1  input  1  source 1 actually read.
- id_use_reg2  input  1  source 2 actually read.
- pipe_hold  input  1  global freeze (e.g. memory wait); scoreboard holds.
- flush  input  1  kill wrong-path instruction in ID this cycle.
- stall  output  1  hold IF/ID, bubble ID/EX.
- busy_vec  output  NUM_REGS  bit i set when register i is pending.

Behaviour:
- State: cnt[i] (CNT_W bits) per register; busy_vec[i] = (cnt[i] != 0). Register 0 never tracked; cnt[0] constant 0.
- Reset (rst_n low, async): all cnt = 0; busy_vec = 0; stall = 0.
- stall combinational from registered state: id_valid && !flush && ((id_use_reg1 && busy[id_read_reg1]) || (id_use_reg2 && busy[id_read_reg2]) || (id_reg_write && busy[id_write_reg])). The WAW term is retained.
- fire = id_valid && !stall && !flush && !pipe_hold.
- Per cycle when pipe_hold = 0:
  - every nonzero cnt[i] decrements by 1;
  - if fire && id_is_load && id_reg_write && id_write_reg != 0, then cnt[id_write_reg] <= LOAD_LAT. This load takes priority over the decrement for that entry.
- pipe_hold = 1: all cnt hold; no load is recorded; stall still reflects current busy state.
- Issue is never granted to a register with cnt != 0, because of the WAW term, so set/decrement collision on a busy entry cannot occur.
- Latency:
  - a load issued in cycle T makes busy[rd] visible from T+1 through T+LOAD_LAT (absent hold);
  - a dependent instruction issues in T+LOAD_LAT+1.
- LOAD_LAT = 1 reproduces the legacy single-bubble behaviour.
- flush: suppresses stall and fire for that cycle. Entries already recorded are unaffected, since issued loads always complete.
- Reset mid-operation: all pending entries discarded immediately; stall deasserts asynchronously.
- Non-load writers (id_is_load = 0) never set entries; forwarding covers them.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined:
  - adds output stall_cycles, 32 bits;
  - increments every cycle where stall && !pipe_hold, wrapping at 2**32-1 -> 0;
  - reset 0 asynchronously.
  - Adds output last_stall_reg, REG_ADDR_W bits: register that caused the most recent stall. Priority when several conflict: reg1, then reg2, then write_reg. Reset 0.
- Undefined: neither port exists; no counter logic.

Test Plan:
- Reset: rst_n = 0 with id_valid = 1, id_read_reg1 = 5 -> stall = 0, busy_vec = 0.
- Load-use, LOAD_LAT = 2:
  - stimulus: load r5 issued cycle 0, then an instruction using r5 as source 1 held in ID;
  - required: busy_vec[5] = 1 in cycles 1-2, stall = 1 in cycles 1-2, dependent issues in cycle 3, busy_vec[5] = 0 in cycle 3.
- Register zero: load to r0, then use r0 -> no stall, busy_vec stays 0.
- WAW plus unused source:
  - load r7, next instruction writes r7 with id_use_reg1 = 0 on read_reg1 = 7 -> stall = 1 via the write term;
  - same with id_reg_write = 0 -> stall = 0.
- pipe_hold:
  - load r3, then pipe_hold = 1 for 4 cycles -> busy_vec[3] stays 1 throughout;
  - after release, clears after 2 more cycles (LOAD_LAT = 2).
- Flush and async reset:
  - flush = 1 while a dependent of a pending r9 sits in ID -> stall = 0, no entry set;
  - assert rst_n low mid-countdown -> busy_vec = 0 same cycle.
  - With HAZARD_STATS_EN: 2-cycle load-use stall -> stall_cycles = 2, last_stall_reg = 5.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// ============================================================================
//  Module      : hazard_scoreboard
//  Description : Per-register load-use hazard scoreboard. Each architectural
//                register carries a countdown that is armed when a load to
//                it issues from ID and counts down to zero as the result
//                becomes forwardable. ID is stalled while any register it
//                reads or writes is still counting.
//                Optional macro HAZARD_STATS_EN adds a stall-cycle counter
//                and the register that caused the most recent stall.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int REG_ADDR_W = 5,
    parameter int NUM_REGS   = 32,
    parameter int LOAD_LAT   = 2,
    parameter int CNT_W      = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic                  id_is_load,
    input  logic [REG_ADDR_W-1:0] id_write_reg,
    input  logic                  id_reg_write,
    input  logic [REG_ADDR_W-1:0] id_read_reg1,
    input  logic [REG_ADDR_W-1:0] id_read_reg2,
    input  logic                  id_use_reg1,
    input  logic                  id_use_reg2,
    input  logic                  pipe_hold,
    input  logic                  flush,
`ifdef HAZARD_STATS_EN
    output logic [31:0]           stall_cycles,
    output logic [REG_ADDR_W-1:0] last_stall_reg,
`endif
    output logic                  stall,
    output logic [NUM_REGS-1:0]   busy_vec
);

    localparam logic [CNT_W-1:0] c_load_lat = CNT_W'(LOAD_LAT);

    logic w_conf_rs1;
    logic w_conf_rs2;
    logic w_conf_rd;
    logic w_fire;
    logic w_set;

    // Individual conflict terms; the write term blocks WAW so a busy entry is
    // never re-armed while it is still counting down.
    assign w_conf_rs1 = id_use_reg1  && busy_vec[id_read_reg1];
    assign w_conf_rs2 = id_use_reg2  && busy_vec[id_read_reg2];
    assign w_conf_rd  = id_reg_write && busy_vec[id_write_reg];

    // Stall depends only on registered state and ID inputs; flush kills it.
    assign stall  = id_valid && !flush && (w_conf_rs1 || w_conf_rs2 || w_conf_rd);
    assign w_fire = id_valid && !stall && !flush && !pipe_hold;
    assign w_set  = w_fire && id_is_load && id_reg_write && (id_write_reg != '0);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        if (i == 0) begin : g_zero
            // Register zero is hardwired and never pending.
            assign busy_vec[i] = 1'b0;
        end else begin : g_track
            logic [CNT_W-1:0] r_cnt;

            // Arm on an issuing load to this register, otherwise count down;
            // everything freezes while the pipeline is held.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (!pipe_hold) begin
                    if (w_set && (id_write_reg == REG_ADDR_W'(i))) begin
                        r_cnt <= c_load_lat;
                    end else if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
            end

            assign busy_vec[i] = (r_cnt != '0);
        end
    end

`ifdef HAZARD_STATS_EN
    logic [REG_ADDR_W-1:0] w_stall_src;
    logic [31:0]           r_stall_cycles;
    logic [REG_ADDR_W-1:0] r_last_stall_reg;

    // Pick the culprit register: source 1 first, then source 2, then dest.
    always_comb begin
        w_stall_src = id_write_reg;
        if (w_conf_rs1) begin
            w_stall_src = id_read_reg1;
        end else if (w_conf_rs2) begin
            w_stall_src = id_read_reg2;
        end
    end

    // Count stall cycles that actually cost a pipeline cycle and remember why.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles   <= '0;
            r_last_stall_reg <= '0;
        end else if (stall && !pipe_hold) begin
            r_stall_cycles   <= r_stall_cycles + 32'd1;
            r_last_stall_reg <= w_stall_src;
        end
    end

    assign stall_cycles   = r_stall_cycles;
    assign last_stall_reg = r_last_stall_reg;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
//  Module      : tb_hazard_scoreboard
//  Description : Directed self-checking bench for hazard_scoreboard
//                (LOAD_LAT = 2). Inputs change 1 ns after the rising edge,
//                outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic        id_is_load;
    logic [4:0]  id_write_reg;
    logic        id_reg_write;
    logic [4:0]  id_read_reg1;
    logic [4:0]  id_read_reg2;
    logic        id_use_reg1;
    logic        id_use_reg2;
    logic        pipe_hold;
    logic        flush;
    logic        stall;
    logic [31:0] busy_vec;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [4:0]  last_stall_reg;
`endif

    int n_checks = 0;
    int n_errors = 0;

    hazard_scoreboard #(
        .REG_ADDR_W (5),
        .NUM_REGS   (32),
        .LOAD_LAT   (2),
        .CNT_W      (3)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_is_load     (id_is_load),
        .id_write_reg   (id_write_reg),
        .id_reg_write   (id_reg_write),
        .id_read_reg1   (id_read_reg1),
        .id_read_reg2   (id_read_reg2),
        .id_use_reg1    (id_use_reg1),
        .id_use_reg2    (id_use_reg2),
        .pipe_hold      (pipe_hold),
        .flush          (flush),
`ifdef HAZARD_STATS_EN
        .stall_cycles   (stall_cycles),
        .last_stall_reg (last_stall_reg),
`endif
        .stall          (stall),
        .busy_vec       (busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic ld, input logic rw, input logic [4:0] wr,
                         input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2);
        id_valid     = v;
        id_is_load   = ld;
        id_reg_write = rw;
        id_write_reg = wr;
        id_read_reg1 = r1;
        id_use_reg1  = u1;
        id_read_reg2 = r2;
        id_use_reg2  = u2;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic load(input logic [4:0] rd);
        drive(1'b1, 1'b1, 1'b1, rd, 5'd1, 1'b1, 5'd2, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        rst_n     = 1'b0;
        pipe_hold = 1'b0;
        flush     = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd5, 1'b1, 5'd0, 1'b0);

        // Reset state with a reader of r5 sitting in ID
        tick();
        sample();
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_busy", busy_vec, 32'd0);
        tick();
        rst_n = 1'b1;
        idle();
        tick();

        // Load-use on r5: load in cycle 0, dependent waits cycles 1-2, issues in 3
        load(5'd5);
        sample();
        check("lu_c0_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 5'd6, 5'd5, 1'b1, 5'd0, 1'b0);
        sample();
        check("lu_c1_busy", busy_vec, 32'h0000_0020);
        check("lu_c1_stall", {31'd0, stall}, 32'd1);
        tick();
        sample();
        check("lu_c2_busy", busy_vec, 32'h0000_0020);
        check("lu_c2_stall", {31'd0, stall}, 32'd1);
        tick();
        sample();
        check("lu_c3_busy", busy_vec, 32'd0);
        check("lu_c3_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();
`ifdef HAZARD_STATS_EN
        sample();
        check("stat_cycles", stall_cycles, 32'd2);
        check("stat_reg", {27'd0, last_stall_reg}, 32'd5);
`endif
        tick();

        // Register zero is never tracked
        load(5'd0);
        sample();
        check("r0_load_stall", {31'd0, stall}, 32'd0);
        tick();
        drive(1'b1, 1'b0, 1'b1, 5'd4, 5'd0, 1'b1, 5'd0, 1'b1);
        sample();
        check("r0_use_stall", {31'd0, stall}, 32'd0);
        check("r0_busy", busy_vec, 32'd0);
        tick();
        idle();
        tick();

        // WAW on r7 with an unused source naming r7
        load(5'd7);
        tick();
        drive(1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
        sample();
        check("waw_stall", {31'd0, stall}, 32'd1);
        tick();
`ifdef HAZARD_STATS_EN
        check("waw_stat_reg", {27'd0, last_stall_reg}, 32'd7);
`endif
        drive(1'b1, 1'b0, 1'b0, 5'd7, 5'd7, 1'b0, 5'd0, 1'b0);
        sample();
        check("waw_nowr_busy", busy_vec, 32'h0000_0080);
        check("waw_nowr_stall", {31'd0, stall}, 32'd0);
        tick();
        idle();
        tick();

        // pipe_hold freezes the r3 countdown; a reader of r3 still sees stall
        load(5'd3);
        tick();
        pipe_hold = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 5'd8, 5'd9, 1'b0, 5'd3, 1'b1);
        for (int k = 0; k < 4; k++) begin
            sample();
            check($sformatf("hold_busy_%0d", k), busy_vec, 32'h0000_0008);
            check($sformatf("hold_stall_%0d", k), {31'd0, stall}, 32'd1);
            tick();
        end
        pipe_hold = 1'b0;
        idle();
        sample();
        check("rel_busy_0", busy_vec, 32'h0000_0008);
        tick();
        sample();
        check("rel_busy_1", busy_vec, 32'h0000_0008);
        tick();
        sample();
        check("rel_busy_2", busy_vec, 32'd0);
        tick();

        // Flush of a dependent load of r9: no stall, nothing recorded for r10
        load(5'd9);
        tick();
        flush = 1'b1;
        drive(1'b1, 1'b1, 1'b1, 5'd10, 5'd9, 1'b1, 5'd0, 1'b0);
        sample();
        check("flush_stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0;
        idle();
        sample();
        check("flush_busy", busy_vec, 32'h0000_0200);
        tick();
        tick();

        // Asynchronous reset mid-countdown on r11
        load(5'd11);
        tick();
        drive(1'b1, 1'b0, 1'b1, 5'd12, 5'd11, 1'b1, 5'd0, 1'b0);
        sample();
        check("arst_pre_busy", busy_vec, 32'h0000_0800);
        check("arst_pre_stall", {31'd0, stall}, 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_busy", busy_vec, 32'd0);
        check("arst_stall", {31'd0, stall}, 32'd0);
`ifdef HAZARD_STATS_EN
        check("arst_stat", stall_cycles, 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        idle();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
